// File: rtl/line_buffer_reader.sv
// Pixel-domain read controller: addresses the line buffer from HDMI timing, repeats each camera line REPEAT times.
// Latency: 1 pix_clk from de_in/hsync_in/vsync_in to de_out/hsync_out/vsync_out/pix_out.
// Backpressure: none; the HDMI timing free-runs and underrun lines are filled with BLANK_VAL.
//
// Ports:
//   pix_clk, rst          pixel clock, asynchronous active-high reset
//   de_in/hsync_in/vsync_in  HDMI timing from the timing generator
//   line_avail            level, a complete camera line is in the buffer
//   rd_addr / rd_data     line buffer read port (data returns 1 cycle after address)
//   pix_out/de_out/hsync_out/vsync_out  re-aligned video out
//   line_done             1-cycle pulse, buffered line fully consumed
//   underrun              sticky, a line was needed but none was available
module line_buffer_reader #(
   parameter int         H_ACTIVE  = 720,
   parameter int         ADDR_W    = 10,
   parameter int         REPEAT    = 2,
   parameter logic [7:0] BLANK_VAL = 8'h10
) (
   input  logic              pix_clk,
   input  logic              rst,
   input  logic              de_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              line_avail,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic [7:0]        pix_out,
   output logic              de_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              line_done,
   output logic              underrun
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE - 1);
   localparam logic [1:0]        REP_LAST  = 2'(REPEAT - 1);

   typedef enum logic [1:0] {
      S_WAIT_VS    = 2'd0,
      S_HBLANK     = 2'd1,
      S_LINE       = 2'd2,
      S_BLANK_LINE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        rep_cnt;
   logic [1:0]        rep_cnt_nxt;
   logic              done_nxt;
   logic              underrun_set;
   logic [ADDR_W-1:0] pix_cnt;
   logic              de_rise;
   logic              de_fall;
   logic              vs_rise;

   // The delayed timing registers double as the previous-cycle copies for edge detection.
   assign de_rise = de_in & ~de_out;
   assign de_fall = ~de_in & de_out;
   assign vs_rise = vsync_in & ~vsync_out;

   // Timing path: fixed one-cycle delay, independent of state.
   always_ff @(posedge pix_clk or posedge rst) begin
      if (rst) begin
         de_out    <= 1'b0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
      end else begin
         de_out    <= de_in;
         hsync_out <= hsync_in;
         vsync_out <= vsync_in;
      end
   end

   // Read address: k-th active cycle of a line presents address k; excess
   // active cycles hold the last pixel rather than wrapping.
   always_ff @(posedge pix_clk or posedge rst) begin
      if (rst) begin
         pix_cnt <= '0;
      end else if (!de_in) begin
         pix_cnt <= '0;
      end else if (pix_cnt != LAST_ADDR) begin
         pix_cnt <= pix_cnt + ADDR_W'(1);
      end
   end

   assign rd_addr = pix_cnt;

   // FSM state register (with the repeat counter and done pulse it drives).
   always_ff @(posedge pix_clk or posedge rst) begin
      if (rst) begin
         state     <= S_WAIT_VS;
         rep_cnt   <= 2'd0;
         line_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         rep_cnt   <= rep_cnt_nxt;
         line_done <= done_nxt;
      end
   end

   // Next-state logic. A vsync rise overrides everything, including a
   // simultaneous de fall, so a partly repeated line never signals done.
   always_comb begin
      state_nxt    = state;
      rep_cnt_nxt  = rep_cnt;
      done_nxt     = 1'b0;
      underrun_set = 1'b0;
      if (vs_rise) begin
         state_nxt   = S_HBLANK;
         rep_cnt_nxt = 2'd0;
      end else begin
         case (state)
            S_WAIT_VS: ;
            S_HBLANK: begin
               if (de_rise) begin
                  // line_avail is only consulted when starting a fresh camera line.
                  if (rep_cnt != 2'd0 || line_avail) begin
                     state_nxt = S_LINE;
                  end else begin
                     state_nxt    = S_BLANK_LINE;
                     underrun_set = 1'b1;
                  end
               end
            end
            S_LINE: begin
               if (de_fall) begin
                  state_nxt = S_HBLANK;
                  if (rep_cnt == REP_LAST) begin
                     rep_cnt_nxt = 2'd0;
                     done_nxt    = 1'b1;
                  end else begin
                     rep_cnt_nxt = rep_cnt + 2'd1;
                  end
               end
            end
            S_BLANK_LINE: begin
               if (de_fall) begin
                  state_nxt = S_HBLANK;
               end
            end
            default: state_nxt = S_WAIT_VS;
         endcase
      end
   end

   always_ff @(posedge pix_clk or posedge rst) begin
      if (rst) begin
         underrun <= 1'b0;
      end else if (underrun_set) begin
         underrun <= 1'b1;
      end
   end

   // Output logic. The state changes on the edge that ends a de transition
   // cycle, so during de_out the state already describes the pixel being shown.
   always_comb begin
      pix_out = 8'h00;
      if (de_out) begin
         pix_out = (state == S_LINE) ? rd_data : BLANK_VAL;
      end
   end

endmodule
